// File: rtl/fifo_umbral_pkg.sv
// Shared transaction-layer definitions for the threshold FIFO.
//  - Field positions inside the 8-bit umbral byte: [3:0] low threshold, [7:4] high threshold.
//  - Default geometry: 6-bit words, 8-word depth.
package fifo_umbral_pkg;

  localparam int UMBRAL_LO_MSB      = 3;
  localparam int UMBRAL_HI_LSB      = 4;
  localparam int DEFAULT_DATA_WIDTH = 6;
  localparam int DEFAULT_ADDR_WIDTH = 3;

endpackage

// File: rtl/fifo_umbral_mem.sv
// Two-port register array backing the FIFO.
//  clk    : write clock
//  we     : write enable
//  waddr  : write address
//  wdata  : write data
//  raddr  : read address
//  rdata  : read data, combinational from the array
// The array has no reset; the owner tracks which entries are valid.
module fifo_umbral_mem #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read: the top samples this into its output register on pop,
  // so a same-cycle write to the same entry (full with push+pop) still sees the old word.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-empty / almost-full thresholds.
//  clk          : single clock, all state on posedge
//  reset        : asynchronous, active-low
//  umbral       : [3:0] low threshold, [7:4] high threshold, compared against count
//  push/data_in : write request and data
//  pop          : read request
//  data_out     : registered read data, one cycle after an accepted pop
//  valid_out    : data_out holds a word popped the previous cycle
//  fifo_empty   : count == 0
//  fifo_full    : count == depth
//  almost_empty : count <= low threshold
//  almost_full  : count >= high threshold
//  fifo_error   : sticky overflow/underflow indicator, cleared only by reset
// Handshake: push and pop are single-cycle requests with no back-pressure signal;
// a request that cannot be accepted is dropped and flagged on fifo_error.
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            umbral,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  fifo_error
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  // Compare width covers both the count and the 4-bit threshold fields.
  localparam int CW = ((ADDR_WIDTH + 1) > 4) ? (ADDR_WIDTH + 1) : 4;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic                  valid_q,  valid_d;
  logic                  error_q,  error_d;

  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] rdata;
  logic [CW-1:0]         count_x, lo_x, hi_x;

  fifo_umbral_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);

  // A pop frees a slot in the same cycle, so a push at full is taken when paired with a pop.
  // An empty FIFO never bypasses data_in to the read side.
  assign pop_ok  = pop  && !fifo_empty;
  assign push_ok = push && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    error_d  = error_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      data_d   = rdata;
      valid_d  = 1'b1;
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + (ADDR_WIDTH+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (ADDR_WIDTH+1)'(1);
    end

    if ((push && fifo_full && !pop) || (pop && fifo_empty)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  // Thresholds are unsigned; values above the depth simply pin the flags.
  assign count_x = CW'(count_q);
  assign lo_x    = CW'(umbral[UMBRAL_LO_MSB:0]);
  assign hi_x    = CW'(umbral[7:UMBRAL_HI_LSB]);

  assign almost_empty = (count_x <= lo_x);
  assign almost_full  = (count_x >= hi_x);

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign fifo_error = error_q;

endmodule

// File: tb/tb_fifo_umbral.sv
module tb_fifo_umbral;

  localparam int DW    = 6;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset;
  logic [7:0]    umbral;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          fifo_empty;
  logic          fifo_full;
  logic          almost_empty;
  logic          almost_full;
  logic          fifo_error;

  int checks = 0;
  int errors = 0;

  // Scoreboard and reference state
  logic [DW-1:0] exp_q[$];
  int            m_count;
  logic          m_err;
  logic          exp_valid;
  logic [DW-1:0] exp_data;

  fifo_umbral dut (
    .clk          (clk),
    .reset        (reset),
    .umbral       (umbral),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .fifo_error   (fifo_error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    exp_q.delete();
    m_count   = 0;
    m_err     = 1'b0;
    exp_valid = 1'b0;
    exp_data  = '0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // One cycle of stimulus; inputs change 1 time unit after the active edge,
  // and the reference model is advanced to what the DUT should show afterwards.
  task automatic drive_cycle(input logic p, input logic [DW-1:0] d, input logic q);
    bit pop_acc, push_acc;
    push    = p;
    data_in = d;
    pop     = q;
    pop_acc  = q && (m_count > 0);
    push_acc = p && ((m_count < DEPTH) || q);
    if ((p && m_count == DEPTH && !q) || (q && m_count == 0)) m_err = 1'b1;
    exp_valid = pop_acc;
    if (pop_acc) exp_data = exp_q.pop_front();
    if (push_acc) exp_q.push_back(d);
    if (push_acc && !pop_acc) m_count++;
    if (pop_acc && !push_acc) m_count--;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset  = 1'b0;
    umbral = 8'h00;
    push   = 1'b0;
    pop    = 1'b0;
    data_in = '0;
    #12;
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: empty/full/ae/af=%b%b%b%b required 1011",
               fifo_empty, fifo_full, almost_empty, almost_full);
    end
    checks++;
    if (data_out !== '0 || valid_out !== 1'b0 || fifo_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: data_out=%h valid=%b err=%b required 00 0 0", data_out, valid_out, fifo_error);
    end
    apply_reset();
    umbral = 8'h62;
    // Mid-stream: underflow to set error, load words, pop one so valid_out is high
    drive_cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, DW'(i + 5), 1'b0);
    drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (valid_out !== 1'b1 || fifo_error !== 1'b1 || fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL reset_prestate: valid=%b err=%b empty=%b required 1 1 0", valid_out, fifo_error, fifo_empty);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (fifo_empty !== 1'b1 || valid_out !== 1'b0 || fifo_error !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_async: empty=%b valid=%b err=%b data=%h required 1 0 0 00",
               fifo_empty, valid_out, fifo_error, data_out);
    end
    apply_reset();
  endtask

  task automatic test_fill_drain();
    apply_reset();
    umbral = 8'h62;
    for (int i = 1; i <= DEPTH; i++) begin
      drive_cycle(1'b1, DW'(i), 1'b0);
      checks++;
      if (almost_full !== (i >= 6) || fifo_full !== (i == DEPTH) || fifo_empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_flags[%0d]: af=%b full=%b empty=%b required %b %b 0",
                 i, almost_full, fifo_full, fifo_empty, i >= 6, i == DEPTH);
      end
    end
    for (int i = 1; i <= DEPTH; i++) begin
      drive_cycle(1'b0, '0, 1'b1);
      checks++;
      if (valid_out !== 1'b1 || data_out !== DW'(i)) begin
        errors++;
        $display("FAIL drain_data[%0d]: valid=%b data=%h required 1 %h", i, valid_out, data_out, DW'(i));
      end
      checks++;
      if (almost_empty !== ((DEPTH - i) <= 2) || fifo_empty !== (i == DEPTH)) begin
        errors++;
        $display("FAIL drain_flags[%0d]: ae=%b empty=%b required %b %b",
                 i, almost_empty, fifo_empty, (DEPTH - i) <= 2, i == DEPTH);
      end
    end
    drive_cycle(1'b0, '0, 1'b0);
    checks++;
    if (valid_out !== 1'b0 || data_out !== DW'(DEPTH) || fifo_error !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: valid=%b data=%h err=%b required 0 %h 0", valid_out, data_out, fifo_error, DW'(DEPTH));
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    umbral = 8'h62;
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, DW'(8'h10 + i), 1'b0);
    drive_cycle(1'b1, 6'h3F, 1'b0);
    checks++;
    if (fifo_error !== 1'b1 || fifo_full !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL overflow_flag: err=%b full=%b valid=%b required 1 1 0", fifo_error, fifo_full, valid_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b0, '0, 1'b1);
      checks++;
      if (valid_out !== exp_valid || data_out !== exp_data) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: valid=%b data=%h required %b %h", i, valid_out, data_out, exp_valid, exp_data);
      end
    end
    checks++;
    if (fifo_empty !== 1'b1 || fifo_error !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: empty=%b err=%b required 1 1", fifo_empty, fifo_error);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    umbral = 8'h62;
    drive_cycle(1'b1, 6'h15, 1'b1);
    checks++;
    if (valid_out !== 1'b0 || fifo_error !== 1'b1 || fifo_empty !== 1'b0 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow: valid=%b err=%b empty=%b ae=%b required 0 1 0 1",
               valid_out, fifo_error, fifo_empty, almost_empty);
    end
    drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 6'h15 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_pop: valid=%b data=%h empty=%b required 1 15 1", valid_out, data_out, fifo_empty);
    end
  endtask

  task automatic test_back_to_back_full();
    apply_reset();
    umbral = 8'h62;
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, DW'(8'h20 + i), 1'b0);
    drive_cycle(1'b1, 6'h2A, 1'b1);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 6'h20 || fifo_full !== 1'b1 || fifo_error !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: valid=%b data=%h full=%b err=%b required 1 20 1 0",
               valid_out, data_out, fifo_full, fifo_error);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      drive_cycle(1'b0, '0, 1'b1);
      checks++;
      if (valid_out !== 1'b1 || data_out !== ((i == DEPTH) ? 6'h2A : DW'(8'h20 + i))) begin
        errors++;
        $display("FAIL full_drain[%0d]: valid=%b data=%h required 1 %h",
                 i, valid_out, data_out, (i == DEPTH) ? 6'h2A : DW'(8'h20 + i));
      end
    end
    checks++;
    if (fifo_empty !== 1'b1 || fifo_error !== 1'b0) begin
      errors++;
      $display("FAIL full_end: empty=%b err=%b required 1 0", fifo_empty, fifo_error);
    end
  endtask

  task automatic test_random_wrap();
    apply_reset();
    umbral = 8'h90;
    // Preload so the interleaved traffic wraps the pointers
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, DW'($urandom_range(0, 63)), 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (i == 20) umbral = 8'hA9;
      drive_cycle(1'($urandom_range(0, 1)), DW'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      checks++;
      if (valid_out !== exp_valid || (exp_valid && data_out !== exp_data)) begin
        errors++;
        $display("FAIL random_data[%0d]: valid=%b data=%h required %b %h", i, valid_out, data_out, exp_valid, exp_data);
      end
      checks++;
      if (almost_full !== 1'b0 || almost_empty !== ((i >= 20) ? 1'b1 : (m_count == 0)) ||
          fifo_empty !== (m_count == 0) || fifo_full !== (m_count == DEPTH) || fifo_error !== m_err) begin
        errors++;
        $display("FAIL random_flags[%0d]: af=%b ae=%b empty=%b full=%b err=%b count_model=%0d err_model=%b",
                 i, almost_full, almost_empty, fifo_empty, fifo_full, fifo_error, m_count, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back_full();
    test_random_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
